exec_sequencer: RTL and testbench



---
 rtl/exec_pkg.sv | 41 ++++
 rtl/alu.sv | 34 +++
 rtl/cond_eval.sv | 34 +++
 rtl/exec_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_exec_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the Y86 SEQ execute stage: icodes, ALU controls,
// condition function codes and the sequencer state type.
`default_nettype none

package exec_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// Shared W-bit ALU: control 00 add, 01 sub (X-Y), 10 and, 11 xor.
// ovf reports two's-complement overflow for add/sub and is 0 otherwise.
`default_nettype none

module alu #(
  parameter int W = 64
) (
  input  logic [1:0]   control,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic [W-1:0] Z,
  output logic         ovf
);

  always_comb begin
    Z   = '0;
    ovf = 1'b0;
    case (control)
      2'b00: begin
        Z   = X + Y;
        ovf = (X[W-1] == Y[W-1]) && (Z[W-1] != X[W-1]);
      end
      2'b01: begin
        Z   = X - Y;
        ovf = (X[W-1] != Y[W-1]) && (Z[W-1] != X[W-1]);
      end
      2'b10:   Z = X & Y;
      default: Z = X ^ Y;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cond_eval.sv
// Branch / conditional-move condition evaluation from {ZF,SF,OF}.
// Function codes above the defined range evaluate to 0.
`default_nettype none

module cond_eval
  import exec_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf, sf, of;
  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/exec_sequencer.sv
// Y86 SEQ execute-stage sequencer: IDLE -> EXEC -> DONE handshake, operand
// select for the shared ALU, condition codes and Cnd. Optional illegal-
// instruction flagging is enabled by defining EXEC_SEQ_ILLEGAL_CHK_EN.
// Revision: 1.0
`default_nettype none

module exec_sequencer
  import exec_pkg::*;
#(
  parameter int         W          = 64,
  parameter logic [2:0] CC_RST     = 3'b100,
  parameter int         STACK_STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic [2:0]   cc,
  output logic         err
);

  localparam logic [W-1:0] STEP     = W'(STACK_STEP);
  localparam logic [W-1:0] NEG_STEP = ~STEP + W'(1);

  state_e         state_q, state_d;
  logic [3:0]     icode_q, ifun_q;
  logic [W-1:0]   valA_q, valB_q, valC_q;
  logic [W-1:0]   valE_q, valE_d;
  logic           cnd_q, cnd_d;
  logic [2:0]     cc_q, cc_d;
  logic           err_q, err_d;

  logic           capture, commit;
  logic [1:0]     alu_ctrl;
  logic [W-1:0]   alu_x, alu_y, alu_z;
  logic           alu_ovf;
  logic           use_alu, cond_en, cond_cnd, illegal;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      icode_q <= '0;
      ifun_q  <= '0;
      valA_q  <= '0;
      valB_q  <= '0;
      valC_q  <= '0;
      valE_q  <= '0;
      cnd_q   <= 1'b0;
      cc_q    <= CC_RST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        icode_q <= icode;
        ifun_q  <= ifun;
        valA_q  <= valA;
        valB_q  <= valB;
        valC_q  <= valC;
      end
      valE_q <= valE_d;
      cnd_q  <= cnd_d;
      cc_q   <= cc_d;
      err_q  <= err_d;
    end
  end

  // FSM: next state; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EXEC;
          capture = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        commit  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // Operand select from the captured instruction
  always_comb begin
    alu_x    = '0;
    alu_y    = '0;
    alu_ctrl = ALU_ADD;
    use_alu  = 1'b0;
    cond_en  = 1'b0;
    case (icode_q)
      I_OPQ: begin
        alu_x    = valB_q;
        alu_y    = valA_q;
        alu_ctrl = ifun_q[1:0];
        use_alu  = 1'b1;
      end
      I_RRMOVQ: begin
        alu_x   = valA_q;
        use_alu = 1'b1;
        cond_en = 1'b1;
      end
      I_IRMOVQ: begin
        alu_x   = valC_q;
        use_alu = 1'b1;
      end
      I_RMMOVQ, I_MRMOVQ: begin
        alu_x   = valB_q;
        alu_y   = valC_q;
        use_alu = 1'b1;
      end
      I_CALL, I_PUSHQ: begin
        alu_x   = valB_q;
        alu_y   = NEG_STEP;
        use_alu = 1'b1;
      end
      I_RET, I_POPQ: begin
        alu_x   = valB_q;
        alu_y   = STEP;
        use_alu = 1'b1;
      end
      I_JXX:   cond_en = 1'b1;
      default: ;
    endcase
  end

`ifdef EXEC_SEQ_ILLEGAL_CHK_EN
  always_comb begin
    illegal = 1'b0;
    if (icode_q > I_POPQ)
      illegal = 1'b1;
    else if (icode_q == I_OPQ)
      illegal = (ifun_q > 4'd3);
    else if (icode_q == I_RRMOVQ || icode_q == I_JXX)
      illegal = (ifun_q > C_G);
    else
      illegal = (ifun_q != 4'd0);
  end
`else
  assign illegal = 1'b0;
`endif

  alu #(.W(W)) u_alu (
    .control (alu_ctrl),
    .X       (alu_x),
    .Y       (alu_y),
    .Z       (alu_z),
    .ovf     (alu_ovf)
  );

  // Evaluated against cc_q, i.e. the flags from before this operation
  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (ifun_q),
    .cnd  (cond_cnd)
  );

  // Results commit at the end of EXEC and are held until the next commit
  always_comb begin
    valE_d = valE_q;
    cnd_d  = cnd_q;
    cc_d   = cc_q;
    err_d  = err_q;
    if (capture)
      err_d = 1'b0;
    if (commit) begin
      err_d  = illegal;
      valE_d = (use_alu && !illegal) ? alu_z : '0;
      cnd_d  = cond_en && !illegal && cond_cnd;
      if (icode_q == I_OPQ && !illegal)
        cc_d = {(alu_z == '0), alu_z[W-1],
                (alu_ctrl == ALU_ADD || alu_ctrl == ALU_SUB) ? alu_ovf : 1'b0};
    end
  end

  assign valE = valE_q;
  assign cnd  = cnd_q;
  assign cc   = cc_q;
  assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (default 64-bit build).
`default_nettype none

module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [3:0]  ifun = 4'h0;
  logic [63:0] valA = '0;
  logic [63:0] valB = '0;
  logic [63:0] valC = '0;
  logic        busy, done, cnd, err;
  logic [63:0] valE;
  logic [2:0]  cc;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef EXEC_SEQ_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  exec_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .icode (icode),
    .ifun  (ifun),
    .valA  (valA),
    .valB  (valB),
    .valC  (valC),
    .busy  (busy),
    .done  (done),
    .valE  (valE),
    .cnd   (cnd),
    .cc    (cc),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Launches one operation from IDLE and returns #1 into its DONE cycle.
  task automatic run_op(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++; if (valE !== 64'h0) $display("FAIL reset_valE got=%h exp=0", valE); else pass_cnt++;
    total_cnt++; if (cnd !== 1'b0) $display("FAIL reset_cnd got=%b exp=0", cnd); else pass_cnt++;
    total_cnt++; if (cc !== 3'b100) $display("FAIL reset_cc got=%b exp=100", cc); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_cnt++;
  endtask

  task automatic test_opq_sub;
    logic [6:0] exp_tab;
    @(negedge clk);
    start = 1'b1; icode = 4'h6; ifun = 4'h1; valA = 64'd7; valB = 64'd5; valC = 64'h0;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL sub_exec_busy got=%b exp=1", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL sub_exec_done got=%b exp=0", done); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b1) $display("FAIL sub_done got=%b exp=1", done); else pass_cnt++;
    total_cnt++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL sub_valE got=%h exp=fffffffffffffffe", valE); else pass_cnt++;
    total_cnt++; if (cc !== 3'b010) $display("FAIL sub_cc got=%b exp=010", cc); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL sub_done_pulse got=%b exp=0", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL sub_idle_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL sub_valE_hold got=%h exp=fffffffffffffffe", valE); else pass_cnt++;
    // cc = {Z0,S1,O0}: yes le l e ne ge g = 1 1 1 0 1 0 0
    exp_tab = 7'b0010111;
    for (int f = 0; f < 7; f++) begin
      run_op(4'h7, 4'(f), 64'h11, 64'h22, 64'h33);
      total_cnt++; if (cnd !== exp_tab[f]) $display("FAIL jxx_after_sub_f%0d got=%b exp=%b", f, cnd, exp_tab[f]); else pass_cnt++;
    end
    total_cnt++; if (valE !== 64'h0) $display("FAIL jxx_valE got=%h exp=0", valE); else pass_cnt++;
    total_cnt++; if (cc !== 3'b010) $display("FAIL jxx_cc got=%b exp=010", cc); else pass_cnt++;
  endtask

  task automatic test_opq_add_ovf;
    run_op(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0);
    total_cnt++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL add_valE got=%h exp=fffffffffffffffe", valE); else pass_cnt++;
    total_cnt++; if (cc !== 3'b011) $display("FAIL add_cc got=%b exp=011", cc); else pass_cnt++;
    // SF=OF=1 -> ge true, l false
    run_op(4'h2, 4'h5, 64'd9, 64'h0, 64'h0);
    total_cnt++; if (cnd !== 1'b1) $display("FAIL cmovge_cnd got=%b exp=1", cnd); else pass_cnt++;
    total_cnt++; if (valE !== 64'd9) $display("FAIL cmovge_valE got=%h exp=9", valE); else pass_cnt++;
    run_op(4'h2, 4'h2, 64'd9, 64'h0, 64'h0);
    total_cnt++; if (cnd !== 1'b0) $display("FAIL cmovl_cnd got=%b exp=0", cnd); else pass_cnt++;
    total_cnt++; if (cc !== 3'b011) $display("FAIL cmov_cc got=%b exp=011", cc); else pass_cnt++;
  endtask

  task automatic test_opq_xor;
    logic [6:0] exp_tab;
    run_op(4'h6, 4'h3, 64'hAAAA_AAAA_AAAA_AAAB, 64'hAAAA_AAAA_AAAA_AAAB, 64'h0);
    total_cnt++; if (valE !== 64'h0) $display("FAIL xor_valE got=%h exp=0", valE); else pass_cnt++;
    total_cnt++; if (cc !== 3'b100) $display("FAIL xor_cc got=%b exp=100", cc); else pass_cnt++;
    exp_tab = 7'b0101011;
    for (int f = 0; f < 7; f++) begin
      run_op(4'h7, 4'(f), 64'h0, 64'h0, 64'h0);
      total_cnt++; if (cnd !== exp_tab[f]) $display("FAIL jxx_after_xor_f%0d got=%b exp=%b", f, cnd, exp_tab[f]); else pass_cnt++;
    end
    run_op(4'h5, 4'h0, 64'h0, 64'h100, 64'h20);
    total_cnt++; if (valE !== 64'h120) $display("FAIL mrmovq_valE got=%h exp=120", valE); else pass_cnt++;
    total_cnt++; if (cc !== 3'b100) $display("FAIL mrmovq_cc got=%b exp=100", cc); else pass_cnt++;
    total_cnt++; if (cnd !== 1'b0) $display("FAIL mrmovq_cnd got=%b exp=0", cnd); else pass_cnt++;
  endtask

  task automatic test_opq_and;
    logic [6:0] exp_tab;
    run_op(4'h6, 4'h2, 64'h3C, 64'hF0, 64'h0);
    total_cnt++; if (valE !== 64'h30) $display("FAIL and_valE got=%h exp=30", valE); else pass_cnt++;
    total_cnt++; if (cc !== 3'b000) $display("FAIL and_cc got=%b exp=000", cc); else pass_cnt++;
    exp_tab = 7'b1110001;
    for (int f = 0; f < 7; f++) begin
      run_op(4'h7, 4'(f), 64'h0, 64'h0, 64'h0);
      total_cnt++; if (cnd !== exp_tab[f]) $display("FAIL jxx_after_and_f%0d got=%b exp=%b", f, cnd, exp_tab[f]); else pass_cnt++;
    end
  endtask

  task automatic test_stack_moves;
    run_op(4'hA, 4'h0, 64'h0, 64'h0, 64'h0);
    total_cnt++; if (valE !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL push_valE got=%h exp=fffffffffffffff8", valE); else pass_cnt++;
    total_cnt++; if (cnd !== 1'b0) $display("FAIL push_cnd got=%b exp=0", cnd); else pass_cnt++;
    run_op(4'hB, 4'h0, 64'h0, 64'h1F8, 64'h0);
    total_cnt++; if (valE !== 64'h200) $display("FAIL pop_valE got=%h exp=200", valE); else pass_cnt++;
    run_op(4'h8, 4'h0, 64'h0, 64'h40, 64'h999);
    total_cnt++; if (valE !== 64'h38) $display("FAIL call_valE got=%h exp=38", valE); else pass_cnt++;
    run_op(4'h9, 4'h0, 64'h0, 64'h38, 64'h0);
    total_cnt++; if (valE !== 64'h40) $display("FAIL ret_valE got=%h exp=40", valE); else pass_cnt++;
    run_op(4'h3, 4'h0, 64'h5, 64'h6, 64'h1234);
    total_cnt++; if (valE !== 64'h1234) $display("FAIL irmovq_valE got=%h exp=1234", valE); else pass_cnt++;
    run_op(4'h4, 4'h0, 64'h5, 64'h1000, 64'h18);
    total_cnt++; if (valE !== 64'h1018) $display("FAIL rmmovq_valE got=%h exp=1018", valE); else pass_cnt++;
    run_op(4'h2, 4'h0, 64'h55, 64'h66, 64'h0);
    total_cnt++; if (valE !== 64'h55) $display("FAIL rrmovq_valE got=%h exp=55", valE); else pass_cnt++;
    total_cnt++; if (cnd !== 1'b1) $display("FAIL rrmovq_cnd got=%b exp=1", cnd); else pass_cnt++;
    run_op(4'h0, 4'h0, 64'h1, 64'h2, 64'h3);
    total_cnt++; if (valE !== 64'h0) $display("FAIL halt_valE got=%h exp=0", valE); else pass_cnt++;
    total_cnt++; if (cc !== 3'b000) $display("FAIL stack_cc got=%b exp=000", cc); else pass_cnt++;
  endtask

  task automatic test_busy_abort;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; icode = 4'h6; ifun = 4'h0; valA = 64'd10; valB = 64'd20; valC = 64'h0;
    @(posedge clk); #1;
    ifun = 4'h1; valA = 64'd5; valB = 64'd5;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b1) $display("FAIL busy_done got=%b exp=1", done); else pass_cnt++;
    total_cnt++; if (valE !== 64'd30) $display("FAIL busy_valE got=%h exp=1e", valE); else pass_cnt++;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL busy_not_queued got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (cc !== 3'b000) $display("FAIL busy_cc got=%b exp=000", cc); else pass_cnt++;
    @(negedge clk);
    start = 1'b1; icode = 4'h6; ifun = 4'h1; valA = 64'd5; valB = 64'd5;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++; if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (cc !== 3'b100) $display("FAIL abort_cc got=%b exp=100", cc); else pass_cnt++;
    total_cnt++; if (valE !== 64'h0) $display("FAIL abort_valE got=%h exp=0", valE); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL abort_no_late_done got=%b exp=0", done); else pass_cnt++;
  endtask

  task automatic test_illegal;
    run_op(4'h6, 4'h0, 64'd1, 64'd2, 64'h0);
    total_cnt++; if (valE !== 64'd3) $display("FAIL pre_illegal_valE got=%h exp=3", valE); else pass_cnt++;
    run_op(4'hC, 4'h0, 64'h7, 64'h8, 64'h9);
    total_cnt++; if (err !== CHK) $display("FAIL icodeC_err got=%b exp=%b", err, CHK); else pass_cnt++;
    total_cnt++; if (valE !== 64'h0) $display("FAIL icodeC_valE got=%h exp=0", valE); else pass_cnt++;
    total_cnt++; if (cnd !== 1'b0) $display("FAIL icodeC_cnd got=%b exp=0", cnd); else pass_cnt++;
    total_cnt++; if (cc !== 3'b000) $display("FAIL icodeC_cc got=%b exp=000", cc); else pass_cnt++;
    run_op(4'h6, 4'h4, 64'd3, 64'd2, 64'h0);
    total_cnt++; if (err !== CHK) $display("FAIL opq_f4_err got=%b exp=%b", err, CHK); else pass_cnt++;
    total_cnt++; if (valE !== (CHK ? 64'h0 : 64'd5)) $display("FAIL opq_f4_valE got=%h exp=%h", valE, (CHK ? 64'h0 : 64'd5)); else pass_cnt++;
    total_cnt++; if (cc !== 3'b000) $display("FAIL opq_f4_cc got=%b exp=000", cc); else pass_cnt++;
    run_op(4'h7, 4'h7, 64'h0, 64'h0, 64'h0);
    total_cnt++; if (cnd !== 1'b0) $display("FAIL jxx_f7_cnd got=%b exp=0", cnd); else pass_cnt++;
    total_cnt++; if (err !== CHK) $display("FAIL jxx_f7_err got=%b exp=%b", err, CHK); else pass_cnt++;
    run_op(4'h1, 4'h0, 64'h0, 64'h0, 64'h0);
    total_cnt++; if (err !== 1'b0) $display("FAIL nop_err_clear got=%b exp=0", err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_opq_sub();
    test_opq_add_ovf();
    test_opq_xor();
    test_opq_and();
    test_stack_moves();
    test_busy_abort();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
